// File: rtl/sram_pkg.sv
// Shared constants and request bundle type for the valid/ready single-port SRAM family.
package sram_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 64;
  localparam int unsigned SRAM_DEPTH      = 512;
  localparam int unsigned SRAM_RSP_DEPTH  = 3;
  localparam int unsigned SRAM_ADDR_WIDTH = $clog2(SRAM_DEPTH);
  localparam int unsigned SRAM_MASK_WIDTH = SRAM_DATA_WIDTH / 8;

  typedef struct packed {
    logic                       write;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
    logic [SRAM_MASK_WIDTH-1:0] wmask;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Register-based response FIFO with clock enable, synchronous flush and occupancy output.
module sram_rsp_fifo #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned OCC_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 flush,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic [OCC_WIDTH-1:0] occ
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [OCC_WIDTH-1:0] FULL_OCC = OCC_WIDTH'(DEPTH);

  logic [WIDTH-1:0]     store_q [DEPTH];
  logic [PTR_WIDTH-1:0] wptr_q, rptr_q;
  logic [OCC_WIDTH-1:0] occ_q;
  logic                 do_push, do_pop;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign do_pop  = clk_en & ~flush & pop & (occ_q != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = clk_en & ~flush & push & ((occ_q != FULL_OCC) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OCC_WIDTH'(1);
        2'b01:   occ_q <= occ_q - OCC_WIDTH'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store_q[wptr_q] <= push_data;
  end

  assign pop_data = store_q[rptr_q];
  assign occ      = occ_q;

endmodule

// File: rtl/sram_sp_rv.sv
// Single-port SRAM with valid/ready requests, byte-masked writes and a credit-protected
// response FIFO so read data survives arbitrary downstream backpressure.
module sram_sp_rv
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned DEPTH      = SRAM_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned RSP_DEPTH  = SRAM_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  localparam int unsigned OCC_WIDTH = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [OCC_WIDTH:0]  RSP_DEPTH_EXT = (OCC_WIDTH + 1)'(RSP_DEPTH);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (RSP_DEPTH < 1) begin : g_bad_rsp_depth
    $error("RSP_DEPTH must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  inflight_q;
  logic [OCC_WIDTH-1:0]  occ;
  logic [OCC_WIDTH:0]    credit;
  logic [DATA_WIDTH-1:0] head;
  logic                  addr_ok, req_fire, rd_fire, wr_fire, pop;

  assign addr_ok = ({1'b0, req_addr} < DEPTH_EXT);
  // Credit counts queued plus in-flight reads so every accepted read has a FIFO slot.
  assign credit    = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight_q};
  assign req_ready = clk_en & ~flush & ~rst & (credit < RSP_DEPTH_EXT);
  assign req_fire  = req_valid & req_ready;
  assign rd_fire   = req_fire & ~req_write;
  assign wr_fire   = req_fire & req_write;

  assign rsp_valid = clk_en & (occ != '0);
  assign rsp_data  = (occ != '0) ? head : '0;
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (wr_fire && addr_ok) begin
      for (int i = 0; i < int'(MASK_WIDTH); i++) begin
        if (req_wmask[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_q       <= '0;
    end else if (flush) begin
      inflight_q <= 1'b0;
    end else if (clk_en) begin
      inflight_q <= rd_fire;
      if (rd_fire) rd_q <= addr_ok ? mem[req_addr] : '0;
    end
  end

  sram_rsp_fifo #(
    .WIDTH    (DATA_WIDTH),
    .DEPTH    (RSP_DEPTH),
    .OCC_WIDTH(OCC_WIDTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .flush    (flush),
    .push     (inflight_q),
    .push_data(rd_q),
    .pop      (pop),
    .pop_data (head),
    .occ      (occ)
  );

endmodule

// File: tb/tb_sram_sp_rv.sv
// Randomized bench for sram_sp_rv: a word-array model plus an in-order queue of expected responses.
module tb_sram_sp_rv;

  localparam int unsigned DW = 64;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW = 9;
  localparam int unsigned MW = 8;

  logic          clk = 1'b0;
  logic          rst, clk_en, flush;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  sram_sp_rv dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: inputs are set at the negedge, sampled 1ns later, model updated, then wait.
  task automatic cycle(output logic acc, output logic got, output logic [DW-1:0] rd);
    cyc++;
    #1;
    acc = req_valid & req_ready;
    got = rsp_valid & rsp_ready;
    rd  = rsp_data;
    if (got) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else check("rsp_data", rsp_data, exp_q.pop_front());
    end
    if (acc) begin
      if (req_write) begin
        for (int b = 0; b < int'(MW); b++)
          if (req_wmask[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
        exp_q.push_back(model_mem[req_addr]);
      end
    end
    if (flush) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
    logic acc, got;
    logic [DW-1:0] rd;
    int n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    do begin
      cycle(acc, got, rd);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("req_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [DW-1:0] d, output int lat);
    logic acc, got;
    logic [DW-1:0] rd;
    lat = 0;
    d = '0;
    got = 1'b0;
    while (!got && lat < 50) begin
      lat++;
      cycle(acc, got, rd);
      if (got) d = rd;
    end
    if (!got) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc, got;
    logic [DW-1:0] rd, d;
    logic [DW-1:0] bp_rsp [$];
    int lat, next, nrsp, first_c, last_c;

    rst = 1'b1; clk_en = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1'b1);
    @(negedge clk);

    for (int a = 0; a < 32; a++) do_req(1'b1, AW'(a), {$urandom, $urandom}, 8'hFF);

    // Write then read, latency 2
    do_req(1'b1, 9'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    do_req(1'b0, 9'd5, '0, '0);
    wait_rsp(d, lat);
    check("rd_latency", 64'(lat), 64'd2);
    check("rd_data", d, 64'hDEADBEEF_CAFEF00D);

    // Byte mask
    do_req(1'b1, 9'd7, {8{8'h11}}, 8'hFF);
    do_req(1'b1, 9'd7, {8{8'hFF}}, 8'h0F);
    do_req(1'b0, 9'd7, '0, '0);
    wait_rsp(d, lat);
    check("mask_data", d, 64'h11111111_FFFFFFFF);

    // Backpressure: only three reads fit
    rsp_ready = 1'b0;
    next = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(next);
      cycle(acc, got, rd);
      if (acc) next++;
    end
    check("bp_accepts", 64'(next), 64'd3);
    check("bp_ready_low", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && (next < 6 || exp_q.size() != 0); i++) begin
      req_valid = (next < 6); req_addr = AW'(next);
      cycle(acc, got, rd);
      if (acc) next++;
      if (got) bp_rsp.push_back(rd);
    end
    req_valid = 1'b0;
    check("bp_all_accepted", 64'(next), 64'd6);
    check("bp_rsp_count", 64'(bp_rsp.size()), 64'd6);
    for (int i = 0; i < 3 && i < bp_rsp.size(); i++) check("bp_order", bp_rsp[i], model_mem[i]);

    // Throughput: 16 back-to-back reads
    nrsp = 0; first_c = -1; last_c = -1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(i);
      cycle(acc, got, rd);
      check("tput_ready", acc, 1'b1);
      if (got) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        nrsp++;
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(acc, got, rd);
      if (got) begin
        last_c = cyc;
        nrsp++;
      end
    end
    check("tput_count", 64'(nrsp), 64'd16);
    check("tput_span", 64'(last_c - first_c), 64'd15);

    // Flush discards the read accepted the cycle before
    do_req(1'b0, 9'd3, '0, '0);
    flush = 1'b1;
    cycle(acc, got, rd);
    flush = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(acc, got, rd);
      if (got) nrsp++;
    end
    check("flush_no_rsp", 64'(nrsp), 64'd0);
    check("flush_valid_low", rsp_valid, 1'b0);
    do_req(1'b0, 9'd3, '0, '0);
    wait_rsp(d, lat);
    check("flush_keep", d, model_mem[3]);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_write = ($urandom_range(0, 99) < 30);
      req_addr  = AW'($urandom_range(0, 31));
      req_wdata = {$urandom, $urandom};
      req_wmask = MW'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 70);
      clk_en    = ($urandom_range(0, 99) < 90);
      flush     = ($urandom_range(0, 99) < 3);
      cycle(acc, got, rd);
    end
    req_valid = 1'b0; rsp_ready = 1'b1; clk_en = 1'b1; flush = 1'b0;
    for (int i = 0; i < 20; i++) cycle(acc, got, rd);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with two queued responses
    rsp_ready = 1'b0;
    do_req(1'b0, 9'd10, '0, '0);
    do_req(1'b0, 9'd11, '0, '0);
    for (int i = 0; i < 3; i++) cycle(acc, got, rd);
    check("ar_pre_valid", rsp_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid_drop", rsp_valid, 1'b0);
    check("ar_data_zero", rsp_data, 64'd0);
    check("ar_ready_low", req_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_ready_high", req_ready, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(acc, got, rd);
      if (got) nrsp++;
    end
    check("ar_no_rsp", 64'(nrsp), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
